// File: rtl/unpack_stream.sv
// Width-down stream converter: splits ISIZE-bit words into OSIZE-bit words,
// carrying partial words across input boundaries, with end-of-line flush.
module unpack_stream #(
  parameter int ISIZE     = 256,
  parameter int OSIZE     = 24,
  parameter int MSB_FIRST = 1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ialign,
  input  logic               ivalid,
  output logic               iready,
  input  logic [ISIZE-1:0]   idata,
  input  logic               ilast,
  output logic               ovalid,
  input  logic               oready,
  output logic [OSIZE-1:0]   odata,
  output logic [OSIZE/8-1:0] omask,
  output logic               olast
);

  localparam int BW = ISIZE + 2 * OSIZE;
  localparam int CW = $clog2(BW + 1);
  localparam int NB = OSIZE / 8;

  logic [BW-1:0]    r_buf;
  logic [CW-1:0]    r_fill;
  logic             r_flush;
  logic             r_ovalid;
  logic [OSIZE-1:0] r_odata;
  logic [NB-1:0]    r_omask;
  logic             r_olast;

  logic             w_ifire;
  logic             w_slot;
  logic             w_full;
  logic             w_part;
  logic             w_oload;
  logic             w_olast;
  logic [CW-1:0]    w_dec;
  logic [CW-1:0]    w_fill_sh;
  logic [CW-1:0]    w_fill_nx;
  logic [OSIZE-1:0] w_word;
  logic [BW-1:0]    w_buf_sh;
  logic [BW-1:0]    w_app;
  logic [NB-1:0]    w_mask;

  // Byte-valid mask for a word built from the oldest min(fill, OSIZE) bits;
  // mask bit i always covers odata[8i+7:8i].
  function automatic logic [NB-1:0] f_mask(input logic [CW-1:0] fill);
    logic [NB-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) begin
      if ((k * 8) < int'(fill)) begin
        if (MSB_FIRST != 0) m[NB-1-k] = 1'b1;
        else                m[k]      = 1'b1;
      end
    end
    return m;
  endfunction

  assign iready    = !r_flush && (r_fill < CW'(2 * OSIZE));
  assign w_ifire   = ivalid && iready;
  assign w_slot    = !r_ovalid || oready;
  assign w_full    = r_fill >= CW'(OSIZE);
  assign w_part    = r_flush && (r_fill != '0) && (r_fill < CW'(OSIZE));
  assign w_oload   = w_slot && (w_full || w_part);
  assign w_olast   = r_flush && (r_fill <= CW'(OSIZE));
  assign w_dec     = w_oload ? (w_full ? CW'(OSIZE) : r_fill) : '0;
  assign w_fill_sh = r_fill - w_dec;
  assign w_fill_nx = w_fill_sh + (w_ifire ? CW'(ISIZE) : '0);
  assign w_mask    = f_mask(r_fill);

  // Bits beyond fill are kept at zero, so shifted-in padding and the
  // OR-append both rely on that invariant.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_word   = r_buf[BW-1 -: OSIZE];
      assign w_buf_sh = w_oload ? (r_buf << OSIZE) : r_buf;
      assign w_app    = {idata, {(BW-ISIZE){1'b0}}} >> w_fill_sh;
    end else begin : g_lsb
      assign w_word   = r_buf[OSIZE-1:0];
      assign w_buf_sh = w_oload ? (r_buf >> OSIZE) : r_buf;
      assign w_app    = {{(BW-ISIZE){1'b0}}, idata} << w_fill_sh;
    end
  endgenerate

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_fill   <= '0;
      r_flush  <= 1'b0;
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_omask  <= '0;
      r_olast  <= 1'b0;
    end else if (ialign) begin
      r_buf    <= '0;
      r_fill   <= '0;
      r_flush  <= 1'b0;
      r_ovalid <= 1'b0;
      r_omask  <= '0;
      r_olast  <= 1'b0;
    end else begin
      r_fill <= w_fill_nx;
      r_buf  <= w_ifire ? (w_buf_sh | w_app) : w_buf_sh;
      if (w_ifire && ilast)
        r_flush <= 1'b1;
      else if (w_oload && w_olast)
        r_flush <= 1'b0;
      if (w_oload) begin
        r_ovalid <= 1'b1;
        r_odata  <= w_word;
        r_omask  <= w_mask;
        r_olast  <= w_olast;
      end else if (oready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  assign ovalid = r_ovalid;
  assign odata  = r_odata;
  assign omask  = r_omask;
  assign olast  = r_olast;

  a_fill_bound: assert property (@(posedge clock) disable iff (!rst_n)
    (r_fill <= CW'(BW)) && (r_fill[2:0] == 3'b000));

endmodule
